instr_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the opcode decoder (control unit) in the single-issue RV64 core.
- Holds the PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Presents the fetched 32-bit instruction, its PC and its opcode field to decode over a valid/ready handshake.
- Handles branch redirects from execute, including squashing an in-flight fetch.

---
 rtl/instr_fetch_if.sv | 37 +++
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side handshakes.
// master = fetch stage, slave = memory / execute / decode environment.
interface instr_fetch_if #(
    parameter int unsigned PC_W = 64
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;

    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic [6:0]      if_opcode;
    logic [31:0]     fetch_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output if_valid, if_instr, if_pc, if_opcode, fetch_count,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  if_valid, if_instr, if_pc, if_opcode, fetch_count,
        output if_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: single-outstanding imem requests, one-entry output
// buffer towards decode, and branch redirect with in-flight squash.
module instr_fetch #(
    parameter int unsigned    PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] redir_pc_q, redir_pc_d;
    logic            squash_q, squash_d;
    logic            if_valid_q, if_valid_d;
    logic [31:0]     if_instr_q, if_instr_d;
    logic [PC_W-1:0] if_pc_q, if_pc_d;
    logic [31:0]     fetch_count_q, fetch_count_d;
    logic [PC_W-1:0] target_c;

    // Redirect targets are forced word-aligned.
    assign target_c = bus.redirect_pc & ~PC_W'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            redir_pc_q    <= '0;
            squash_q      <= 1'b0;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redir_pc_q    <= redir_pc_d;
            squash_q      <= squash_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redir_pc_d    = redir_pc_q;
        squash_d      = squash_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            S_REQ: begin
                if (bus.redirect_valid) begin
                    pc_d = target_c;
                    // A grant in the redirect cycle fetched the old PC: squash it.
                    if (bus.imem_gnt) begin
                        squash_d   = 1'b1;
                        redir_pc_d = target_c;
                        state_d    = S_WAIT;
                    end
                end else if (bus.imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (bus.redirect_valid) begin
                        pc_d     = target_c;
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else if (squash_q) begin
                        pc_d     = redir_pc_q;
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        if_instr_d = bus.imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    squash_d   = 1'b1;
                    redir_pc_d = target_c;
                end
            end
            S_HOLD: begin
                // Redirect wins over a simultaneous decode accept.
                if (bus.redirect_valid) begin
                    if_valid_d = 1'b0;
                    pc_d       = target_c;
                    state_d    = S_REQ;
                end else if (bus.if_ready) begin
                    if_valid_d    = 1'b0;
                    pc_d          = pc_q + PC_W'(4);
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign bus.imem_req    = (state_q == S_REQ);
    assign bus.imem_addr   = pc_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.if_instr    = if_instr_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_opcode   = if_instr_q[6:0];
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// phase, checked against a transaction-level model of the delivered stream.
module tb_instr_fetch;
    localparam int unsigned PC_W     = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic clk;
    logic rst_n;

    instr_fetch_if #(.PC_W(PC_W)) bus ();

    instr_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Memory contents: directed overrides, otherwise a hash of the address.
    logic [31:0] mem_ovr [logic [63:0]];

    // Reference model: next PC to be delivered to decode and accepted count.
    logic [63:0] exp_pc;
    logic [31:0] m_count;

    // Memory responder state.
    bit          pend;
    logic [63:0] pend_addr;
    int          dly;
    int unsigned gnt_pct, ready_pct;
    int          dly_min, dly_max;

    // Previous-cycle observations used for hold/stability expectations.
    bit prev_valid, prev_ready, prev_redir, prev_req, prev_gnt;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc     = RESET_PC;
        m_count    = 32'd0;
        pend       = 1'b0;
        dly        = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_redir = 1'b0;
        prev_req   = 1'b0;
        prev_gnt   = 1'b0;
    endtask

    // One clock cycle: check outputs at the negedge, drive inputs, update the model.
    task automatic tick(input bit redir, input logic [63:0] tgt);
        bit          g, rv, rd, vld;
        logic [31:0] w;
        rv  = pend && (dly == 0);
        g   = (bus.imem_req === 1'b1) && ($urandom_range(99) < gnt_pct);
        rd  = ($urandom_range(99) < ready_pct);
        vld = (bus.if_valid === 1'b1);
        w   = mem_word(exp_pc);

        chk("fetch_count", 64'(bus.fetch_count), 64'(m_count));
        if (bus.imem_req === 1'b1) chk("imem_addr", bus.imem_addr, exp_pc);
        if (pend) chk("one_outstanding", 64'({bus.imem_req, bus.if_valid}), 64'd0);
        if (vld) begin
            chk("if_pc", bus.if_pc, exp_pc);
            chk("if_instr", 64'(bus.if_instr), 64'(w));
            chk("if_opcode", 64'(bus.if_opcode), 64'(w[6:0]));
        end
        if (prev_valid) chk("hold_valid", 64'(bus.if_valid), 64'(!(prev_ready || prev_redir)));
        if (prev_req && !prev_gnt && !prev_redir) chk("req_stable", 64'(bus.imem_req), 64'd1);

        bus.imem_gnt       = g;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = rv ? mem_word(pend_addr) : $urandom;
        bus.if_ready       = rd;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;

        prev_valid = vld;
        prev_ready = rd;
        prev_redir = redir;
        prev_req   = (bus.imem_req === 1'b1);
        prev_gnt   = g;
        if (g) pend_addr = bus.imem_addr;

        @(posedge clk);
        if (rv) pend = 1'b0;
        else if (pend) dly--;
        if (g) begin
            pend = 1'b1;
            dly  = $urandom_range(dly_max, dly_min) - 1;
        end
        if (redir) exp_pc = tgt & ~64'h3;
        else if (vld && rd) begin
            m_count++;
            exp_pc += 64'd4;
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] base;
        logic [31:0] c0;
        rst_n              = 1'b0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        gnt_pct = 100; ready_pct = 100; dly_min = 1; dly_max = 1;
        mem_ovr[64'h0] = 32'h0000_0033;
        mem_ovr[64'h4] = 32'h0000_3003;
        mem_ovr[64'h8] = 32'hDEAD_BEEF;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
        chk("rst_if_instr", 64'(bus.if_instr), 64'd0);
        chk("rst_if_pc", bus.if_pc, 64'd0);
        chk("rst_count", 64'(bus.fetch_count), 64'd0);
        chk("rst_req", 64'(bus.imem_req), 64'd1);
        chk("rst_addr", bus.imem_addr, RESET_PC);
        rst_n = 1'b1;

        // 1: first fetch, two-cycle latency
        tick(1'b0, '0);
        chk("t1_req_low_in_wait", 64'(bus.imem_req), 64'd0);
        tick(1'b0, '0);
        chk("t1_if_valid", 64'(bus.if_valid), 64'd1);
        chk("t1_opcode", 64'(bus.if_opcode), 64'(7'b0110011));
        chk("t1_if_pc", bus.if_pc, 64'h0);
        tick(1'b0, '0);
        chk("t1_next_addr", bus.imem_addr, 64'h4);
        chk("t1_count", 64'(bus.fetch_count), 64'd1);

        // 2: decode stalls for 5 cycles
        ready_pct = 0;
        tick(1'b0, '0);
        tick(1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_instr", 64'(bus.if_instr), 64'h3003);
            chk("t2_hold_pc", bus.if_pc, 64'h4);
            chk("t2_no_req", 64'(bus.imem_req), 64'd0);
            tick(1'b0, '0);
        end
        ready_pct = 100;
        tick(1'b0, '0);
        chk("t2_count", 64'(bus.fetch_count), 64'd2);
        chk("t2_next_addr", bus.imem_addr, 64'h8);

        // 3: redirect while waiting; the in-flight word must be dropped
        dly_min = 2; dly_max = 2;
        tick(1'b0, '0);
        tick(1'b1, 64'h100);
        dly_min = 1; dly_max = 1;
        tick(1'b0, '0);
        chk("t3_squash_valid", 64'(bus.if_valid), 64'd0);
        chk("t3_addr", bus.imem_addr, 64'h100);
        tick(1'b0, '0);
        tick(1'b0, '0);
        chk("t3_if_pc", bus.if_pc, 64'h100);
        chk("t3_not_dead", 64'(bus.if_instr == 32'hDEAD_BEEF), 64'd0);

        // 4: redirect and ready together in hold
        tick(1'b1, 64'h202);
        chk("t4_valid_drop", 64'(bus.if_valid), 64'd0);
        chk("t4_count", 64'(bus.fetch_count), 64'd2);
        chk("t4_addr", bus.imem_addr, 64'h200);

        // 5: grant withheld, redirect on the second cycle
        gnt_pct = 0;
        tick(1'b0, '0);
        chk("t5_addr_c1", bus.imem_addr, 64'h200);
        tick(1'b1, 64'h40);
        for (int i = 0; i < 2; i++) begin
            chk("t5_req", 64'(bus.imem_req), 64'd1);
            chk("t5_addr", bus.imem_addr, 64'h40);
            tick(1'b0, '0);
        end
        gnt_pct = 100;

        // Peak throughput: one instruction per three cycles
        c0 = m_count;
        repeat (30) tick(1'b0, '0);
        chk("throughput", 64'(bus.fetch_count), 64'(c0 + 32'd10));

        // Randomized traffic with occasional redirects
        gnt_pct = 60; ready_pct = 60; dly_min = 1; dly_max = 3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 6) tick(1'b1, 64'($urandom_range(32'hFFFF, 0)));
            else tick(1'b0, '0);
        end
        while (pend || bus.if_valid === 1'b1) begin
            ready_pct = 100;
            tick(1'b0, '0);
        end

        // 6: reset during a pending fetch, then a stale rvalid
        gnt_pct = 100; dly_min = 3; dly_max = 3;
        while (bus.imem_req !== 1'b1) tick(1'b0, '0);
        base = pend_addr;
        tick(1'b0, '0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(bus.if_valid), 64'd0);
        chk("t6_rst_instr", 64'(bus.if_instr), 64'd0);
        chk("t6_rst_pc", bus.if_pc, 64'd0);
        chk("t6_rst_count", 64'(bus.fetch_count), 64'd0);
        chk("t6_rst_addr", bus.imem_addr, RESET_PC);
        model_reset();
        @(negedge clk);
        rst_n           = 1'b1;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(base);
        bus.if_ready    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        chk("t6_stale_ignored", 64'(bus.if_valid), 64'd0);
        chk("t6_req", 64'(bus.imem_req), 64'd1);
        chk("t6_addr", bus.imem_addr, RESET_PC);
        dly_min = 1; dly_max = 1;
        tick(1'b0, '0);
        tick(1'b0, '0);
        chk("t6_first_instr", 64'(bus.if_instr), 64'h33);

        // fetch_count wrap
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count_q;
        m_count = 32'hFFFF_FFFF;
        chk("wrap_pre", 64'(bus.fetch_count), 64'hFFFF_FFFF);
        tick(1'b0, '0);
        chk("wrap_zero", 64'(bus.fetch_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
